// File: rtl/intpol2_pkg.sv
// intpol2_pkg: shared constants and FSM encoding for the interpolator output packer.
package intpol2_pkg;
    localparam int OUT_W = 16;
    localparam logic [OUT_W-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [OUT_W-1:0] Q15_MIN = 16'h8000;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        OUT       = 2'd2
    } state_e;
endpackage

// File: rtl/intpol2_round_sat.sv
// intpol2_round_sat: round-half-up and saturate a fixed-point sample to signed OUT_WIDTH bits.
module intpol2_round_sat
    import intpol2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int M_BITS     = 31,
    parameter int OUT_WIDTH  = OUT_W
) (
    input  logic [DATA_WIDTH-1:0] x_i,
    output logic [OUT_WIDTH-1:0]  y_o,
    output logic                  sat_o
);
    localparam int SH = M_BITS - (OUT_WIDTH - 1);
    localparam logic signed [DATA_WIDTH:0] R_MAX = (DATA_WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH:0] R_MIN = ~R_MAX;
    localparam logic [OUT_WIDTH-1:0] Y_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] Y_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [DATA_WIDTH:0] r;
    logic hi, lo;

    // one guard bit keeps the +1 round from wrapping at the positive extreme
    always_comb begin
        r     = ($signed({x_i[DATA_WIDTH-1], x_i}) >>> SH) + $signed({{DATA_WIDTH{1'b0}}, x_i[SH-1]});
        hi    = r > R_MAX;
        lo    = r < R_MIN;
        sat_o = hi || lo;
        y_o   = hi ? Y_MAX : lo ? Y_MIN : r[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/intpol2_iq_out_packer.sv
// intpol2_iq_out_packer: pops I/Q pairs from the output FIFOs, converts to Q1.15
// and emits {Q,I} words on a valid/ready stream with frame-boundary last.
module intpol2_iq_out_packer
    import intpol2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int M_BITS     = 31,
    parameter int OUT_WIDTH  = OUT_W,
    parameter int FLEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable_i,
    input  logic [FLEN_WIDTH-1:0]  frame_len_i,
    input  logic                   Empty_i,
    input  logic [DATA_WIDTH-1:0]  data_I_i,
    input  logic [DATA_WIDTH-1:0]  data_Q_i,
    output logic                   Read_Enable_fifo,
    output logic [2*OUT_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   sat_flag_o,
    output logic [FLEN_WIDTH-1:0]  sample_cnt_o
);
    state_e                  state_q, state_d;
    logic [2*OUT_WIDTH-1:0]  tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    sat_q, sat_d;
    logic [FLEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    en_q;
    logic [OUT_WIDTH-1:0]    i_conv, q_conv;
    logic                    i_sat, q_sat;
    logic                    can_pop, pop;

    intpol2_round_sat #(.DATA_WIDTH(DATA_WIDTH), .M_BITS(M_BITS), .OUT_WIDTH(OUT_WIDTH)) u_rs_i (
        .x_i   (data_I_i),
        .y_o   (i_conv),
        .sat_o (i_sat)
    );

    intpol2_round_sat #(.DATA_WIDTH(DATA_WIDTH), .M_BITS(M_BITS), .OUT_WIDTH(OUT_WIDTH)) u_rs_q (
        .x_i   (data_Q_i),
        .y_o   (q_conv),
        .sat_o (q_sat)
    );

    always_comb begin
        can_pop  = enable_i && !Empty_i;
        pop      = 1'b0;
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        cnt_d    = cnt_q;
        sat_d    = (enable_i && !en_q) ? 1'b0 : sat_q;
        case (state_q)
            IDLE: begin
                pop     = can_pop;
                state_d = can_pop ? WAIT_DATA : IDLE;
            end
            WAIT_DATA: begin
                tdata_d  = {q_conv, i_conv};
                tvalid_d = 1'b1;
                tlast_d  = (frame_len_i != '0) && (cnt_q == frame_len_i - FLEN_WIDTH'(1));
                sat_d    = sat_d || i_sat || q_sat;
                state_d  = OUT;
            end
            OUT: begin
                // on a back-to-back pop the old word stays visible for the WAIT_DATA cycle
                if (m_tready) begin
                    cnt_d    = tlast_q ? '0 : cnt_q + FLEN_WIDTH'(1);
                    pop      = can_pop;
                    state_d  = can_pop ? WAIT_DATA : IDLE;
                    tvalid_d = can_pop;
                    tlast_d  = can_pop && tlast_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            en_q     <= enable_i;
        end
    end

    // gate the combinational pop so the FIFOs see nothing while reset is held
    assign Read_Enable_fifo = pop && rstn;
    assign m_tdata          = tdata_q;
    assign m_tvalid         = tvalid_q;
    assign m_tlast          = tlast_q;
    assign sat_flag_o       = sat_q;
    assign sample_cnt_o     = cnt_q;
endmodule

// File: tb/tb_intpol2_iq_out_packer.sv
// tb_intpol2_iq_out_packer: scoreboard bench with a FIFO model feeding directed I/Q vectors.
module tb_intpol2_iq_out_packer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        enable_i;
    logic [15:0] frame_len_i;
    logic        Empty_i;
    logic [31:0] data_I_i;
    logic [31:0] data_Q_i;
    logic        Read_Enable_fifo;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        sat_flag_o;
    logic [15:0] sample_cnt_o;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [15:0] c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_i[64];
    logic [31:0] mem_q[64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pops = 0;
    int          total = 0;
    int          bad = 0;
    logic        prev_acc = 1'b0;

    intpol2_iq_out_packer dut (
        .clk              (clk),
        .rstn             (rstn),
        .enable_i         (enable_i),
        .frame_len_i      (frame_len_i),
        .Empty_i          (Empty_i),
        .data_I_i         (data_I_i),
        .data_Q_i         (data_Q_i),
        .Read_Enable_fifo (Read_Enable_fifo),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .sat_flag_o       (sat_flag_o),
        .sample_cnt_o     (sample_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    assign Empty_i = (wr_ptr == rd_ptr);

    // FIFO model: read data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (Read_Enable_fifo) begin
            chk("pop_while_empty", {31'b0, Empty_i}, 32'd0);
            data_I_i <= mem_i[rd_ptr % 64];
            data_Q_i <= mem_q[rd_ptr % 64];
            rd_ptr   <= rd_ptr + 1;
            pops     <= pops + 1;
        end
    end

    // monitor: the cycle right after an accepted word carries stale data and is skipped
    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready && !prev_acc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", m_tdata, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data", m_tdata, e.d);
                chk("word_last", {31'b0, m_tlast}, {31'b0, e.l});
                chk("word_cnt", {16'b0, sample_cnt_o}, {16'b0, e.c});
            end
            prev_acc <= 1'b1;
        end else begin
            prev_acc <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] q);
        mem_i[wr_ptr % 64] = i;
        mem_q[wr_ptr % 64] = q;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic l, input logic [15:0] c);
        exp_q.push_back('{d: d, l: l, c: c});
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        repeat (3) step();
        chk(nm, exp_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!m_tvalid && n < 50) begin
            step();
            n++;
        end
        chk(nm, {31'b0, m_tvalid}, 32'd1);
    endtask

    task automatic reset_dut();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int p0;
        rstn        = 1'b1;
        enable_i    = 1'b0;
        frame_len_i = 16'd0;
        m_tready    = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_re", {31'b0, Read_Enable_fifo}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
        chk("rst_sat", {31'b0, sat_flag_o}, 32'd0);
        chk("rst_cnt", {16'b0, sample_cnt_o}, 32'd0);
        rstn = 1'b1;

        // rounding and packing, frame_len 0
        step();
        m_tready = 1'b1;
        enable_i = 1'b1;
        push(32'h4000_0000, 32'h0000_8000); expect_word(32'h0001_4000, 1'b0, 16'd0);
        push(32'hFFFF_8000, 32'h0001_7FFF); expect_word(32'h0001_0000, 1'b0, 16'd1);
        push(32'h8000_8000, 32'h7FFF_7FFF); expect_word(32'h7FFF_8001, 1'b0, 16'd2);
        wait_drain("round_drain");
        chk("round_sat_clear", {31'b0, sat_flag_o}, 32'd0);

        // saturation is sticky until enable rises again
        reset_dut();
        push(32'h7FFF_FFFF, 32'h8000_0000); expect_word(32'h8000_7FFF, 1'b0, 16'd0);
        wait_drain("sat_drain");
        chk("sat_set", {31'b0, sat_flag_o}, 32'd1);
        repeat (5) step();
        chk("sat_sticky", {31'b0, sat_flag_o}, 32'd1);
        step(); enable_i = 1'b0;
        step(); enable_i = 1'b1;
        step();
        chk("sat_cleared", {31'b0, sat_flag_o}, 32'd0);

        // framing: 7 words with frame length 3
        reset_dut();
        frame_len_i = 16'd3;
        p0 = pops;
        for (int k = 1; k <= 7; k++) begin
            logic [15:0] kv;
            logic [15:0] nk;
            kv = 16'(k);
            nk = -kv;
            push({kv, 16'h0000}, {nk, 16'h0000});
            expect_word({nk, kv}, (k % 3) == 0, 16'((k - 1) % 3));
        end
        wait_drain("frame_drain");
        chk("frame_pops", pops - p0, 32'd7);
        chk("frame_cnt_end", {16'b0, sample_cnt_o}, 32'd1);

        // backpressure
        reset_dut();
        frame_len_i = 16'd0;
        m_tready = 1'b0;
        push(32'h0005_0000, 32'h0006_0000); expect_word(32'h0006_0005, 1'b0, 16'd0);
        push(32'h0007_0000, 32'h0008_0000); expect_word(32'h0008_0007, 1'b0, 16'd1);
        wait_valid("bp_valid");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
            chk("bp_tdata", m_tdata, 32'h0006_0005);
            chk("bp_no_pop", {31'b0, Read_Enable_fifo}, 32'd0);
        end
        step();
        m_tready = 1'b1;
        #1 chk("bp_pop_on_hs", {31'b0, Read_Enable_fifo}, 32'd1);
        wait_drain("bp_drain");

        // empty / enable gating
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("empty_no_pop", {31'b0, Read_Enable_fifo}, 32'd0);
        end
        enable_i = 1'b0;
        push(32'h1234_5678, 32'hFEDC_8000);
        push(32'h0001_0000, 32'h0002_0000);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("disabled_no_pop", {31'b0, Read_Enable_fifo}, 32'd0);
        end
        p0 = pops;
        expect_word(32'hFEDD_1234, 1'b0, 16'd0);
        enable_i = 1'b1;
        #1 chk("enable_pop", {31'b0, Read_Enable_fifo}, 32'd1);
        step();
        enable_i = 1'b0;
        wait_drain("en_drop_drain");
        chk("en_drop_pops", pops - p0, 32'd1);
        chk("en_drop_idle", {31'b0, m_tvalid}, 32'd0);
        chk("en_drop_cnt", {16'b0, sample_cnt_o}, 32'd1);

        // async reset while a word is held in OUT
        m_tready = 1'b0;
        enable_i = 1'b1;
        wait_valid("rst_mid_valid");
        chk("rst_mid_pre_cnt", {16'b0, sample_cnt_o}, 32'd1);
        step();
        rstn = 1'b0;
        #1;
        chk("rst_mid_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_mid_tlast", {31'b0, m_tlast}, 32'd0);
        chk("rst_mid_tdata", m_tdata, 32'd0);
        chk("rst_mid_cnt", {16'b0, sample_cnt_o}, 32'd0);
        enable_i = 1'b0;
        m_tready = 1'b1;
        repeat (2) step();
        rstn = 1'b1;
        repeat (4) step();
        chk("rst_mid_after_cnt", {16'b0, sample_cnt_o}, 32'd0);
        chk("rst_mid_after_valid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_mid_no_words", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
